// File: rtl/display_mux_hex_if.sv
// display_mux_hex_if
//   Bundles the load-side data bus and the board-side segment/anode pins of
//   display_mux_hex.
//   master : datapath/driver side (drives valor, apagar, supr_zeros, carregar[, pisca])
//   slave  : display controller side (drives pendente, saida, anodo)
//   Signals:
//     valor      4*NUM_DIGITOS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//     apagar     per-digit blank mask, 1 = dark
//     supr_zeros 1 = suppress leading zeros
//     carregar   load strobe into the pending buffer
//     pisca      per-digit blink mask (only when DISPLAY_BLINK_EN is defined)
//     pendente   pending data not yet shown
//     saida      segments {g,f,e,d,c,b,a}, active-low
//     anodo      digit enables, active-low
interface display_mux_hex_if #(
    parameter int NUM_DIGITOS = 4
);
    logic [4*NUM_DIGITOS-1:0] valor;
    logic [NUM_DIGITOS-1:0]   apagar;
    logic                     supr_zeros;
    logic                     carregar;
`ifdef DISPLAY_BLINK_EN
    logic [NUM_DIGITOS-1:0]   pisca;
`endif
    logic                     pendente;
    logic [6:0]               saida;
    logic [NUM_DIGITOS-1:0]   anodo;

`ifdef DISPLAY_BLINK_EN
    modport master (output valor, apagar, supr_zeros, carregar, pisca,
                    input  pendente, saida, anodo);
    modport slave  (input  valor, apagar, supr_zeros, carregar, pisca,
                    output pendente, saida, anodo);
`else
    modport master (output valor, apagar, supr_zeros, carregar,
                    input  pendente, saida, anodo);
    modport slave  (input  valor, apagar, supr_zeros, carregar,
                    output pendente, saida, anodo);
`endif
endinterface

// File: rtl/display_mux_hex.sv
// display_mux_hex
//   Time-multiplexed driver for NUM_DIGITOS common-anode hex digits sharing one
//   segment bus. Scans one digit per DIV_REFRESH clocks with a one-clock all-off
//   gap after every slot change, supports per-digit blanking and leading-zero
//   suppression, and applies new data only at frame start (double buffered).
//   Optional feature macro: DISPLAY_BLINK_EN adds the pisca blink mask and a
//   blink phase that toggles every DIV_PISCA digit slots.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    display_mux_hex_if.slave (load bus in, pendente/saida/anodo out)

// Per-digit decode and blank evaluation. zeros_daqui/zeros_acima form a chain
// from the most significant digit down: "this digit and all above are zero".
module display_mux_hex_digit #(
    parameter bit PODE_SUPRIMIR = 1'b1   // 0 for digit 0: never zero-suppressed
) (
    input  logic [3:0] nib,
    input  logic       zeros_acima,
    input  logic       supr_zeros,
    input  logic       apagar,
    input  logic       pisca_off,
    output logic [6:0] seg,
    output logic       blank,
    output logic       zeros_daqui
);
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign seg         = hex7(nib);
    assign zeros_daqui = (nib == 4'h0) && zeros_acima;
    assign blank       = apagar | (PODE_SUPRIMIR & supr_zeros & zeros_daqui) | pisca_off;
endmodule

module display_mux_hex #(
    parameter int NUM_DIGITOS = 4,
    parameter int DIV_REFRESH = 50000,
    parameter int DIV_PISCA   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    display_mux_hex_if.slave   bus
);
    localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam int PW = $clog2(DIV_REFRESH);
    localparam logic [PW-1:0] PRE_FIM = PW'(DIV_REFRESH - 1);
    localparam logic [IW-1:0] IDX_FIM = IW'(NUM_DIGITOS - 1);

    // ---------------- scan timing ----------------
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          tick;
    logic          inicio_quadro;

    assign tick          = (presc == PRE_FIM);
    assign inicio_quadro = tick && (idx == IDX_FIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= (idx == IDX_FIM) ? '0 : idx + 1'b1;
        end
    end

    // ---------------- double buffer ----------------
    logic [NUM_DIGITOS-1:0][3:0] val_in;
    logic [NUM_DIGITOS-1:0][3:0] pend_val, ativo_val;
    logic [NUM_DIGITOS-1:0]      pend_apg, ativo_apg;
    logic                        pend_sz,  ativo_sz;
    logic                        pendente_r;

    assign val_in       = bus.valor;
    assign bus.pendente = pendente_r;

    // Active is updated from the pending contents held before this edge, so a
    // load coinciding with frame start lands in pending and keeps pendente set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_apg   <= '0;
            pend_sz    <= 1'b0;
            ativo_val  <= '0;
            ativo_apg  <= '0;
            ativo_sz   <= 1'b0;
            pendente_r <= 1'b0;
        end else begin
            if (inicio_quadro && pendente_r) begin
                ativo_val <= pend_val;
                ativo_apg <= pend_apg;
                ativo_sz  <= pend_sz;
            end
            if (bus.carregar) begin
                pend_val   <= val_in;
                pend_apg   <= bus.apagar;
                pend_sz    <= bus.supr_zeros;
                pendente_r <= 1'b1;
            end else if (inicio_quadro) begin
                pendente_r <= 1'b0;
            end
        end
    end

    // ---------------- blink ----------------
    logic [NUM_DIGITOS-1:0] pisca_off;

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;
    localparam logic [BW-1:0] PISCA_FIM = BW'(DIV_PISCA - 1);

    logic [BW-1:0]          pisca_cnt;
    logic                   fase_on;
    logic [NUM_DIGITOS-1:0] pend_pisca, ativo_pisca;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pisca_cnt <= '0;
            fase_on   <= 1'b1;
        end else if (tick) begin
            if (pisca_cnt == PISCA_FIM) begin
                pisca_cnt <= '0;
                fase_on   <= ~fase_on;
            end else begin
                pisca_cnt <= pisca_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pisca  <= '0;
            ativo_pisca <= '0;
        end else begin
            if (inicio_quadro && pendente_r) ativo_pisca <= pend_pisca;
            if (bus.carregar)                pend_pisca  <= bus.pisca;
        end
    end

    assign pisca_off = fase_on ? '0 : ativo_pisca;
`else
    assign pisca_off = '0;
`endif

    // ---------------- per-digit decode ----------------
    logic [NUM_DIGITOS-1:0][6:0] seg_dig;
    logic [NUM_DIGITOS-1:0]      blank_dig;
    logic [NUM_DIGITOS:0]        zacima;

    assign zacima[NUM_DIGITOS] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_dig
        display_mux_hex_digit #(.PODE_SUPRIMIR(g > 0)) u_dig (
            .nib        (ativo_val[g]),
            .zeros_acima(zacima[g+1]),
            .supr_zeros (ativo_sz),
            .apagar     (ativo_apg[g]),
            .pisca_off  (pisca_off[g]),
            .seg        (seg_dig[g]),
            .blank      (blank_dig[g]),
            .zeros_daqui(zacima[g])
        );
    end

    // ---------------- registered pin drive ----------------
    // The tick edge loads all-off: this is the anti-ghost gap while the
    // index moves to the next digit.
    logic [6:0]             saida_nxt, saida_r;
    logic [NUM_DIGITOS-1:0] anodo_nxt, anodo_r;

    always_comb begin
        saida_nxt = '1;
        anodo_nxt = '1;
        if (!tick && !blank_dig[idx]) begin
            saida_nxt      = seg_dig[idx];
            anodo_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_r <= '1;
            anodo_r <= '1;
        end else begin
            saida_r <= saida_nxt;
            anodo_r <= anodo_nxt;
        end
    end

    assign bus.saida = saida_r;
    assign bus.anodo = anodo_r;
endmodule
